// File: rtl/system_0_cpu_0_oci_dct_packer_if.sv
// Frame/atom bus between the CPU trace port, the DCT packer and the OCI trace consumer.
// overflow_count exists only when OCI_DCT_OVERFLOW_CNT_EN is defined.
interface system_0_cpu_0_oci_dct_packer_if;
    logic        atom_valid;
    logic [1:0]  atom;
    logic        dct_flush;
    logic        test_ending;
    logic        frame_ready;
    logic        frame_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_has_ended;
`ifdef OCI_DCT_OVERFLOW_CNT_EN
    logic [7:0]  overflow_count;
`endif

    modport master (
`ifdef OCI_DCT_OVERFLOW_CNT_EN
        input  overflow_count,
`endif
        output atom_valid, atom, dct_flush, test_ending, frame_ready,
        input  frame_valid, dct_buffer, dct_count, test_has_ended
    );

    modport slave (
`ifdef OCI_DCT_OVERFLOW_CNT_EN
        output overflow_count,
`endif
        input  atom_valid, atom, dct_flush, test_ending, frame_ready,
        output frame_valid, dct_buffer, dct_count, test_has_ended
    );
endinterface

// File: rtl/system_0_cpu_0_oci_dct_packer.sv
// Packs 2-bit DCT atoms into 15-slot frames and sequences test_ending -> test_has_ended.
// Define OCI_DCT_OVERFLOW_CNT_EN to add the saturating dropped-atom counter (overflow_count).
//
// state    | meaning
// ST_RUN   | normal packing
// ST_DRAIN | test_ending seen; packing continues until everything has left
// ST_ENDED | all data drained; atoms ignored until reset
module system_0_cpu_0_oci_dct_packer (
    input  logic clk,
    input  logic reset,
    system_0_cpu_0_oci_dct_packer_if.slave bus
);
    localparam int unsigned SLOTS = 15;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ENDED} state_t;

    state_t              state_q, state_d;
    logic [2*SLOTS-1:0]  acc_buf_q, acc_buf_d;
    logic [3:0]          acc_cnt_q, acc_cnt_d;
    logic                acc_closed_q, acc_closed_d;
    logic                flush_pend_q, flush_pend_d;
    logic [2*SLOTS-1:0]  out_buf_q, out_buf_d;
    logic [3:0]          out_cnt_q, out_cnt_d;
    logic                out_valid_q, out_valid_d;

    logic                active, atom_in, out_free, start_flush, flush_eff;
    logic                hard_close, load;
    logic [2*SLOTS-1:0]  nxt_buf, load_buf;
    logic [3:0]          nxt_cnt, load_cnt;
    logic [4:0]          slot_lsb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            acc_buf_q    <= '0;
            acc_cnt_q    <= '0;
            acc_closed_q <= 1'b0;
            flush_pend_q <= 1'b0;
            out_buf_q    <= '0;
            out_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_buf_q    <= acc_buf_d;
            acc_cnt_q    <= acc_cnt_d;
            acc_closed_q <= acc_closed_d;
            flush_pend_q <= flush_pend_d;
            out_buf_q    <= out_buf_d;
            out_cnt_q    <= out_cnt_d;
            out_valid_q  <= out_valid_d;
        end
    end

    always_comb begin
        active      = (state_q != ST_ENDED);
        atom_in     = active && bus.atom_valid;
        out_free    = !out_valid_q || bus.frame_ready;
        start_flush = bus.dct_flush || (bus.test_ending && state_q == ST_RUN);
        flush_eff   = flush_pend_q || start_flush;
        slot_lsb    = {acc_cnt_q, 1'b0};

        nxt_buf      = acc_buf_q;
        nxt_cnt      = acc_cnt_q;
        hard_close   = 1'b0;
        load         = 1'b0;
        load_buf     = '0;
        load_cnt     = '0;
        acc_buf_d    = acc_buf_q;
        acc_cnt_d    = acc_cnt_q;
        acc_closed_d = acc_closed_q;
        flush_pend_d = flush_pend_q;

        if (acc_closed_q) begin
            // A closed accumulator only waits for the output register; the
            // atom arriving on the transfer cycle starts the next frame.
            if (out_free) begin
                load         = 1'b1;
                load_buf     = acc_buf_q;
                load_cnt     = acc_cnt_q;
                acc_buf_d    = '0;
                acc_cnt_d    = '0;
                acc_closed_d = 1'b0;
                flush_pend_d = 1'b0;
                if (atom_in) begin
                    acc_buf_d[1:0] = bus.atom;
                    acc_cnt_d      = 4'd1;
                    acc_closed_d   = (bus.atom == 2'b11);
                end
            end else begin
                flush_pend_d = flush_eff;
            end
        end else begin
            if (atom_in) begin
                nxt_buf[slot_lsb +: 2] = bus.atom;
                nxt_cnt                = acc_cnt_q + 4'd1;
            end
            hard_close = (nxt_cnt == 4'(SLOTS)) || (atom_in && bus.atom == 2'b11);
            if ((hard_close || (flush_eff && nxt_cnt != 4'd0)) && out_free) begin
                load         = 1'b1;
                load_buf     = nxt_buf;
                load_cnt     = nxt_cnt;
                acc_buf_d    = '0;
                acc_cnt_d    = '0;
                flush_pend_d = 1'b0;
            end else begin
                // A flush-only close keeps appending until the output frees up.
                acc_buf_d    = nxt_buf;
                acc_cnt_d    = nxt_cnt;
                acc_closed_d = hard_close;
                flush_pend_d = flush_eff && (nxt_cnt != 4'd0);
            end
        end

        out_buf_d   = out_buf_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_buf_d   = load_buf;
            out_cnt_d   = load_cnt;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.frame_ready) begin
            out_valid_d = 1'b0;
        end

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (bus.test_ending) state_d = ST_DRAIN;
            ST_DRAIN: if (acc_cnt_q == 4'd0 && !flush_pend_q && !out_valid_q) state_d = ST_ENDED;
            ST_ENDED: state_d = ST_ENDED;
            default:  state_d = ST_RUN;
        endcase
    end

    assign bus.frame_valid    = out_valid_q;
    assign bus.dct_buffer     = out_buf_q;
    assign bus.dct_count      = out_cnt_q;
    assign bus.test_has_ended = (state_q == ST_ENDED);

`ifdef OCI_DCT_OVERFLOW_CNT_EN
    logic [7:0] ovf_q, ovf_d;
    logic       drop;

    always_comb begin
        drop  = atom_in && acc_closed_q && !out_free;
        ovf_d = ovf_q;
        if (drop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_q <= '0;
        else       ovf_q <= ovf_d;
    end

    assign bus.overflow_count = ovf_q;
`endif
endmodule
